// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point add/sub/min/max unit.
//   Operands use an IEEE-754-style layout {sign, biased exponent, mantissa}.
//   Subnormal inputs are flushed to signed zero. Rounding is round-to-nearest-even.
// Ports:
//   clk_i    clock; all state updates on the rising edge
//   rst_i    synchronous active-high reset
//   start_i  operation request, sampled only while idle
//   op_i     00 add, 01 sub (A-B), 10 min, 11 max
//   a_i,b_i  operands
//   r_o      registered result, valid from the done cycle and held until the next done
//   done_o   one-cycle completion pulse
//   busy_o   high whenever an operation is in flight
//   flags_o  {invalid, overflow, underflow, inexact}, registered with r_o
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic [EXP_W+MAN_W:0] r_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic [3:0]           flags_o
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;  // hidden bit + mantissa + guard/round/sticky
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W:0]   EXP_ONE  = 1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic             sa_q, sb_q, sign_q, sub_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic [MAN_W-1:0] ma_q, mb_q;
  logic [EXP_W:0]   exp_q;
  logic [SW-1:0]    big_q, small_q;
  logic [SW:0]      sig_q;
  logic [W-1:0]     r_q;
  logic [3:0]       flags_q;

  // ---------------- ALIGN: operand ordering, shift, special cases
  logic             a_ge_b, a_lt_b, special;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [EXP_W-1:0] e_big, e_small, e_diff;
  logic [MAN_W-1:0] m_big, m_small;
  logic [SW-1:0]    small_ext, small_sh, shift_mask, small_al_d;
  logic [31:0]      diff32;
  logic [W-1:0]     a_val, b_val, spec_r_d;
  logic [3:0]       spec_f_d;

  always_comb begin
    a_ge_b     = {ea_q, ma_q} >= {eb_q, mb_q};
    e_big      = a_ge_b ? ea_q : eb_q;
    e_small    = a_ge_b ? eb_q : ea_q;
    m_big      = a_ge_b ? ma_q : mb_q;
    m_small    = a_ge_b ? mb_q : ma_q;
    e_diff     = e_big - e_small;
    diff32     = 32'(e_diff);
    small_ext  = {1'b1, m_small, 3'b000};
    small_sh   = small_ext >> e_diff;
    shift_mask = ~({SW{1'b1}} << e_diff);
    // Bits shifted past the sticky position are OR-ed into it.
    if (diff32 >= 32'(MAN_W + 3)) small_al_d = {{(SW-1){1'b0}}, 1'b1};
    else small_al_d = small_sh | {{(SW-1){1'b0}}, |(small_ext & shift_mask)};
  end

  always_comb begin
    a_nan  = (ea_q == EXP_ONES) && (ma_q != '0);
    b_nan  = (eb_q == EXP_ONES) && (mb_q != '0);
    a_inf  = (ea_q == EXP_ONES) && (ma_q == '0);
    b_inf  = (eb_q == EXP_ONES) && (mb_q == '0);
    a_zero = (ea_q == '0);
    b_zero = (eb_q == '0);
    a_val  = {sa_q, ea_q, ma_q};
    b_val  = {sb_q, eb_q, mb_q};
    // Numeric ordering with -0 < +0.
    if (sa_q != sb_q) a_lt_b = sa_q;
    else if (sa_q)    a_lt_b = {eb_q, mb_q} < {ea_q, ma_q};
    else              a_lt_b = {ea_q, ma_q} < {eb_q, mb_q};
    special  = op_q[1] | a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    spec_r_d = '0;
    spec_f_d = 4'b0000;
    if (op_q[1]) begin
      if (a_nan && b_nan) begin
        spec_r_d = QNAN;
        spec_f_d = 4'b1000;
      end
      else if (a_nan)  spec_r_d = b_val;
      else if (b_nan)  spec_r_d = a_val;
      else if (op_q[0]) spec_r_d = a_lt_b ? b_val : a_val;
      else              spec_r_d = a_lt_b ? a_val : b_val;
    end
    else if (a_nan || b_nan || (a_inf && b_inf && (sa_q != sb_q))) begin
      spec_r_d = QNAN;
      spec_f_d = 4'b1000;
    end
    else if (a_inf)             spec_r_d = a_val;
    else if (b_inf)             spec_r_d = b_val;
    else if (a_zero && b_zero)  spec_r_d = {sa_q & sb_q, {(W-1){1'b0}}};
    else if (a_zero)            spec_r_d = b_val;
    else                        spec_r_d = a_val;
  end

  // ---------------- ADD / NORM / ROUND datapath
  logic [SW:0]      sum_d, sig_norm_d;
  logic [EXP_W:0]   exp_norm_d, exp_r;
  logic             norm_exit;
  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] man_f;
  logic [2:0]       grs;
  logic             rup;
  logic [W-1:0]     rnd_r_d;
  logic [3:0]       rnd_f_d;

  always_comb begin
    sum_d = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
  end

  always_comb begin
    sig_norm_d = sig_q;
    exp_norm_d = exp_q;
    norm_exit  = 1'b1;
    if (sig_q[SW]) begin
      sig_norm_d = {1'b0, sig_q[SW:2], sig_q[1] | sig_q[0]};
      exp_norm_d = exp_q + EXP_ONE;
    end
    // A zero significand is an exact cancellation; leave it for ROUND to turn into +0.
    else if (!sig_q[SW-1] && (sig_q[SW-2:0] != '0) && (exp_q != EXP_ONE)) begin
      sig_norm_d = {1'b0, sig_q[SW-2:0], 1'b0};
      exp_norm_d = exp_q - EXP_ONE;
      norm_exit  = 1'b0;
    end
  end

  always_comb begin
    mant    = sig_q[SW-1:3];
    grs     = sig_q[2:0];
    rup     = grs[2] & (grs[1] | grs[0] | mant[0]);
    mant_r  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rup};
    exp_r   = mant_r[MAN_W+1] ? exp_q + EXP_ONE : exp_q;
    man_f   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    rnd_r_d = {sign_q, exp_r[EXP_W-1:0], man_f};
    rnd_f_d = {3'b000, |grs};
    if (sig_q[SW-1:0] == '0) begin
      rnd_r_d = '0;
      rnd_f_d = 4'b0000;
    end
    else if (!mant[MAN_W]) begin
      rnd_r_d = {sign_q, {(W-1){1'b0}}};
      rnd_f_d = 4'b0011;
    end
    else if (exp_r >= {1'b0, EXP_ONES}) begin
      rnd_r_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      rnd_f_d = 4'b0101;
    end
  end

  // ---------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_ALIGN;
      S_ALIGN: state_d = special ? S_DONE : S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  if (norm_exit) state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      big_q   <= '0;
      small_q <= '0;
      sig_q   <= '0;
      r_q     <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          op_q <= op_i;
          sa_q <= a_i[W-1];
          sb_q <= b_i[W-1] ^ (op_i == 2'b01);
          ea_q <= a_i[W-2:MAN_W];
          eb_q <= b_i[W-2:MAN_W];
          ma_q <= (a_i[W-2:MAN_W] == '0) ? '0 : a_i[MAN_W-1:0];
          mb_q <= (b_i[W-2:MAN_W] == '0) ? '0 : b_i[MAN_W-1:0];
        end
        S_ALIGN: begin
          sign_q  <= a_ge_b ? sa_q : sb_q;
          sub_q   <= sa_q ^ sb_q;
          exp_q   <= {1'b0, e_big};
          big_q   <= {1'b1, m_big, 3'b000};
          small_q <= small_al_d;
          if (special) begin
            r_q     <= spec_r_d;
            flags_q <= spec_f_d;
          end
        end
        S_ADD:  sig_q <= sum_d;
        S_NORM: begin
          sig_q <= sig_norm_d;
          exp_q <= exp_norm_d;
        end
        S_ROUND: begin
          r_q     <= rnd_r_d;
          flags_q <= rnd_f_d;
        end
        default: ;
      endcase
    end
  end

  assign r_o     = r_q;
  assign flags_o = flags_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq (EXP_W=8, MAN_W=23).
module tb_fp_addsub_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic [31:0] r;
  logic        done, busy;
  logic [3:0]  flags;

  int tests = 0;
  int failed = 0;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .a_i(a), .b_i(b), .r_o(r), .done_o(done), .busy_o(busy), .flags_o(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  fl;
    int          lat;   // 0: latency not checked
  } vec_t;
  vec_t vecs[$];

  function automatic void addv(logic [1:0] o, logic [31:0] va, logic [31:0] vb,
                               logic [31:0] vr, logic [3:0] vf, int vl);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.r = vr; v.fl = vf; v.lat = vl;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts an operation, scrambles the inputs while busy, waits for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                        output logic [31:0] vr, output logic [3:0] vf,
                        output int lat, output logic tmo);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    tmo = !done;
    vr = r;
    vf = flags;
  endtask

  initial begin
    logic [31:0] vr;
    logic [3:0]  vf;
    int          lat, ndone;
    logic        tmo, saw_done;

    //   op     A             B             R             flags    lat
    addv(2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 5);
    addv(2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000, 0);
    addv(2'b01, 32'h3F800001, 32'h3F800000, 32'h34000000, 4'b0000, 28);
    addv(2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001, 5);
    addv(2'b00, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001, 5);
    addv(2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101, 5);
    addv(2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2);
    addv(2'b11, 32'h80000000, 32'h00000000, 32'h00000000, 4'b0000, 2);
    addv(2'b10, 32'h7FC00000, 32'h40000000, 32'h40000000, 4'b0000, 2);
    addv(2'b00, 32'h40400000, 32'hBF800000, 32'h40000000, 4'b0000, 5);
    addv(2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000, 2);
    addv(2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2);
    addv(2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000, 2);
    addv(2'b00, 32'h80000000, 32'h00000000, 32'h00000000, 4'b0000, 2);
    addv(2'b00, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000, 2);
    addv(2'b11, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 4'b1000, 2);
    addv(2'b10, 32'hC0000000, 32'h3F800000, 32'hC0000000, 4'b0000, 2);
    addv(2'b11, 32'hC0000000, 32'h3F800000, 32'h3F800000, 4'b0000, 2);
    addv(2'b10, 32'h00000000, 32'h80000000, 32'h80000000, 4'b0000, 2);
    addv(2'b00, 32'h3F800000, 32'h00800000, 32'h3F800000, 4'b0001, 5);
    addv(2'b01, 32'h00800001, 32'h00800000, 32'h00000000, 4'b0011, 5);
    addv(2'b00, 32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 4'b0101, 5);
    addv(2'b00, 32'h3F800001, 32'h3F800000, 32'h40000000, 4'b0001, 5);
    addv(2'b01, 32'h3F800000, 32'h3F000000, 32'h3F000000, 4'b0000, 6);
    addv(2'b01, 32'hBF800000, 32'h3F800000, 32'hC0000000, 4'b0000, 5);

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_r", 64'(r), 64'd0);
    chk("reset_flags", 64'(flags), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vr, vf, lat, tmo);
      chk($sformatf("v%0d_timeout", i), 64'(tmo), 64'd0);
      chk($sformatf("v%0d_r", i), 64'(vr), 64'(vecs[i].r));
      chk($sformatf("v%0d_flags", i), 64'(vf), 64'(vecs[i].fl));
      if (vecs[i].lat != 0) chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
      chk($sformatf("v%0d_hold_r", i), 64'(r), 64'(vecs[i].r));
    end

    // Reset in cycle 3 aborts the operation: no done, R back to zero.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h3F800000; b = 32'h3F800000;
    saw_done = 1'b0;
    @(negedge clk); start = 1'b0; saw_done |= done;
    @(negedge clk); saw_done |= done;
    @(negedge clk); saw_done |= done; rst = 1'b1;
    @(negedge clk); saw_done |= done; rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      saw_done |= done;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    chk("abort_r", 64'(r), 64'd0);
    chk("abort_flags", 64'(flags), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);

    run_op(2'b00, 32'h3F800000, 32'h3F800000, vr, vf, lat, tmo);
    chk("after_abort_r", 64'(vr), 64'h40000000);
    chk("after_abort_latency", 64'(lat), 64'd5);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 32'h3F800000; b = 32'h3F800000;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_priority_busy", 64'(busy), 64'd0);
    chk("rst_priority_r", 64'(r), 64'd0);

    // Start pulses while busy and during DONE are ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h40400000; b = 32'hBF800000;
    ndone = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = (c == 2 || c == 4 || c == 5);
      if (c == 2 || c == 4) begin a = 32'h7F800000; b = 32'h7F800000; op = 2'b01; end
      if (done) ndone++;
    end
    start = 1'b0;
    chk("busy_start_done_count", 64'(ndone), 64'd1);
    chk("busy_start_r", 64'(r), 64'h40000000);
    chk("busy_start_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa field width; W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  2  00 add, 01 sub (A-B), 10 min, 11 max.
REQ-007 A, B  input  W  IEEE-754-style operands: sign, biased exponent, mantissa.
REQ-008 R  output  W  registered result.
REQ-009 done  output  1  one-cycle pulse; R and flags valid from this cycle.
REQ-010 busy  output  1  high in every state other than IDLE.
REQ-011 flags  output  4  {invalid, overflow, underflow, inexact}, registered with R.

Function
REQ-012 FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
REQ-013 IDLE with start=1 captures A, B, op and moves to ALIGN; start outside IDLE is ignored.
REQ-014 Inputs changing while busy=1 do not affect the operation in flight.
REQ-015 Subnormal inputs are flushed to signed zero before processing.
REQ-016 Sub: B sign inverted at capture; remaining datapath identical to add.
REQ-017 ALIGN: larger-magnitude operand selected; smaller significand right-shifted by the exponent difference in one cycle, with guard, round and sticky bits kept; a shift >= MAN_W+3 leaves only sticky.
REQ-018 ADD: MAN_W+4-bit significand add or subtract of the aligned operands, carry-out kept.
REQ-019 NORM: on carry, right-shift 1 and exponent+1 in the first NORM cycle, OR-ing the shifted-out bit into sticky.
REQ-020 NORM: otherwise left-shift 1 bit per cycle, exponent-1, while MSB=0 and exponent>1; exit when MSB=1 or exponent=1.
REQ-021 ROUND: round-to-nearest-even on guard/round/sticky; a mantissa carry from rounding increments the exponent.
REQ-022 Latency: start accepted in cycle 0; done=1 in cycle 5+N, where N = number of NORM left-shift cycles (N=0 without cancellation).
REQ-023 Special cases (either operand NaN/inf/zero, or op=min/max) bypass ADD/NORM/ROUND: ALIGN goes straight to DONE; done=1 in cycle 2.
REQ-024 Any NaN operand, or inf-inf of opposite effective sign: R = canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0), invalid=1.
REQ-025 Inf with finite operand, or inf+inf of same sign: R = that inf, no flags.
REQ-026 Exact zero sum: R = +0, except (-0)+(-0) = -0.
REQ-027 Exponent reaching all-ones after NORM/ROUND: R = signed inf, overflow=1, inexact=1.
REQ-028 Normalized result with exponent <1 (MSB=0 at exponent 1): R = signed zero, underflow=1, inexact=1.
REQ-029 inexact=1 whenever any of guard/round/sticky was nonzero before rounding.
REQ-030 min/max: smaller/larger numeric value; -0 < +0; one NaN operand returns the other operand; two NaNs return qNaN with invalid=1.
REQ-031 DONE lasts exactly one cycle, then IDLE; start in DONE is ignored.
REQ-032 R and flags hold their values until the next done.

Reset
REQ-033 rst=1: state IDLE, R=0, flags=0, done=0, busy=0, all internal registers cleared.
REQ-034 rst asserted mid-operation aborts it: no done pulse for that operation; R keeps the reset value.
REQ-035 rst has priority over start in the same cycle.

Verification (defaults EXP_W=8, MAN_W=23)
REQ-036 add 0x3F800000+0x3F800000 -> R=0x40000000, flags=0, done in cycle 5.
REQ-037 sub 0x3F800000-0x3F800000 -> R=0x00000000, flags=0; and sub 0x3F800001-0x3F800000 -> R=0x34000000, done in cycle 5+23.
REQ-038 add 0x3F800000+0x33800000 (tie) -> R=0x3F800000, inexact=1; add 0x3F800001+0x33800000 -> R=0x3F800002, inexact=1.
REQ-039 add 0x7F7FFFFF+0x7F7FFFFF -> R=0x7F800000, overflow=1, inexact=1; sub 0x7F800000-0x7F800000 -> R=0x7FC00000, invalid=1, done in cycle 2.
REQ-040 max 0x80000000,0x00000000 -> 0x00000000; min 0x7FC00000,0x40000000 -> 0x40000000, done in cycle 2.
REQ-041 start add, assert rst in cycle 3 -> no done pulse, R=0, busy=0; a new start after rst=0 completes normally; start pulses while busy=1 produce no extra done.
